// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial BCD add/subtract sequencer: one shared complement stage and digit adder, LSD first.
// Optional macro SIGN_MAG_EN adds a FIX pass that turns a negative difference into sign-magnitude.
module bcd_serial_addsub_ctrl #(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              m,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              cout,
  output logic              neg,
  output logic              err
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

`ifdef SIGN_MAG_EN
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [4*NDIG-1:0] a_q, a_d, b_q, b_d;
  logic              m_q, m_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;
  logic [3:0]        res_q [NDIG];
  logic [3:0]        res_d [NDIG];
`ifdef SIGN_MAG_EN
  logic              neg_q, neg_d;
`endif

  logic [3:0]      a_dig [NDIG];
  logic [3:0]      b_dig [NDIG];
  logic [NDIG-1:0] bad_dig;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign a_dig[gi]           = a_q[4*gi +: 4];
      assign b_dig[gi]           = b_q[4*gi +: 4];
      assign result[4*gi +: 4]   = res_q[gi];
      assign bad_dig[gi]         = (a[4*gi +: 4] > 4'd9) || (b[4*gi +: 4] > 4'd9);
    end
  endgenerate

  // Shared digit datapath: optional 9's complement of the second operand, then BCD add.
  logic [3:0] op_a, op_b, op_x, sum_dig;
  logic       op_cpl, sum_carry;
  logic [4:0] sum_raw;
  logic       last_dig;

  always_comb begin
    op_a   = a_dig[idx_q];
    op_b   = b_dig[idx_q];
    op_cpl = m_q;
`ifdef SIGN_MAG_EN
    // FIX negates the stored digit: 0 + (9 - r) + carry, carry seeded with 1.
    if (state_q == S_FIX) begin
      op_a   = 4'd0;
      op_b   = res_q[idx_q];
      op_cpl = 1'b1;
    end
`endif
    op_x    = op_cpl ? (4'd9 - op_b) : op_b;
    sum_raw = {1'b0, op_a} + {1'b0, op_x} + {4'd0, carry_q};
    if (sum_raw > 5'd9) begin
      sum_dig   = 4'(sum_raw - 5'd10);
      sum_carry = 1'b1;
    end else begin
      sum_dig   = sum_raw[3:0];
      sum_carry = 1'b0;
    end
    last_dig = (idx_q == IDXW'(NDIG - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    res_d   = res_q;
`ifdef SIGN_MAG_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          err_d   = 1'b0;
          idx_d   = '0;
          carry_d = m;
`ifdef SIGN_MAG_EN
          neg_d   = 1'b0;
`endif
          if (|bad_dig) begin
            err_d  = 1'b1;
            cout_d = 1'b0;
            for (int i = 0; i < NDIG; i++) res_d[i] = 4'd0;
            state_d = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        res_d[idx_q] = sum_dig;
        carry_d      = sum_carry;
        idx_d        = idx_q + IDXW'(1);
        if (last_dig) begin
          cout_d  = sum_carry;
          idx_d   = '0;
          state_d = S_DONE;
`ifdef SIGN_MAG_EN
          if (m_q && !sum_carry) begin
            carry_d = 1'b1;
            state_d = S_FIX;
          end
`endif
        end
      end
`ifdef SIGN_MAG_EN
      S_FIX: begin
        res_d[idx_q] = sum_dig;
        carry_d      = sum_carry;
        idx_d        = idx_q + IDXW'(1);
        if (last_dig) begin
          idx_d   = '0;
          neg_d   = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NDIG; i++) res_q[i] <= 4'd0;
`ifdef SIGN_MAG_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      res_q   <= res_d;
`ifdef SIGN_MAG_EN
      neg_q   <= neg_d;
`endif
    end
  end

`ifdef SIGN_MAG_EN
  assign busy = (state_q == S_ADD) || (state_q == S_FIX);
  assign neg  = neg_q;
`else
  assign busy = (state_q == S_ADD);
  assign neg  = 1'b0;
`endif
  assign done = (state_q == S_DONE);
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Randomized bench for bcd_serial_addsub_ctrl: integer-arithmetic reference model, latency and handshake checks.
// Honors SIGN_MAG_EN when compiled with the same define as the design.
module tb_bcd_serial_addsub_ctrl;
  localparam int NDIG = 2;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n, start, m;
  logic [W-1:0] a, b;
  logic         busy, done, cout, neg, err;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_serial_addsub_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .m(m),
    .busy(busy), .done(done), .result(result), .cout(cout), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tm,
                        input bit poke, input string tag);
    int           p = 1;
    int           av, bv, s, lat, k;
    bit           bad, busy_seen, got_done;
    logic [W-1:0] e_res;
    logic         e_cout, e_neg;

    for (int i = 0; i < NDIG; i++) p = p * 10;
    bad    = has_bad(ta) || has_bad(tbv);
    e_neg  = 1'b0;
    if (bad) begin
      e_res = '0; e_cout = 1'b0; lat = 0;
    end else begin
      av  = bcd2int(ta);
      bv  = bcd2int(tbv);
      lat = NDIG;
      s   = tm ? (av - bv + p) : (av + bv);
      e_cout = (s >= p);
      e_res  = int2bcd(s % p);
`ifdef SIGN_MAG_EN
      if (tm && !e_cout) begin
        e_res = int2bcd(bv - av);
        e_neg = 1'b1;
        lat   = 2 * NDIG;
      end
`endif
    end

    @(negedge clk);
    a = ta; b = tbv; m = tm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); m = 1'($urandom);

    k = 0; busy_seen = 0; got_done = 0;
    while (k < 40) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        break;
      end
      if (busy) busy_seen = 1;
      start = (poke && k == 0) ? 1'b1 : 1'b0;
      k++;
    end
    start = 1'b0;

    check({tag, ".done_seen"}, 32'(got_done), 32'd1);
    check({tag, ".latency"},   32'(k), 32'(lat));
    check({tag, ".busy_seen"}, 32'(busy_seen), 32'(!bad));
    check({tag, ".result"},    32'(result), 32'(e_res));
    check({tag, ".cout"},      32'(cout), 32'(e_cout));
    check({tag, ".neg"},       32'(neg), 32'(e_neg));
    check({tag, ".err"},       32'(err), 32'(bad));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    $display("op %s a=%h b=%h m=%0d -> result=%h cout=%b neg=%b err=%b cycles=%0d",
             tag, ta, tbv, tm, result, cout, neg, err, k);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".hold"},       32'(result), 32'(e_res));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.flags", {29'd0, cout, neg, err}, 32'd0);
    rst_n = 1'b1;

    run_op(8'h47, 8'h38, 1'b0, 0, "add_47_38");
    run_op(8'h99, 8'h01, 1'b0, 0, "add_99_01");
    run_op(8'h52, 8'h17, 1'b1, 0, "sub_52_17");
    run_op(8'h17, 8'h52, 1'b1, 0, "sub_17_52");
    run_op(8'h3A, 8'h11, 1'b0, 0, "err_3A");
    run_op(8'h25, 8'h25, 1'b1, 0, "sub_equal");
    run_op(8'h00, 8'h99, 1'b1, 0, "sub_00_99");
    run_op(8'h64, 8'h29, 1'b0, 1, "add_poke");
    run_op(8'h31, 8'h58, 1'b1, 1, "sub_poke");

    // Reset in the middle of ADD: everything clears and no done appears.
    @(negedge clk);
    a = 8'h12; b = 8'h34; m = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.result", 32'(result), 32'd0);
    check("midrst.flags", {29'd0, cout, neg, err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst.no_done", 32'(done), 32'd0);
    end
    $display("op midrst a=12 b=34 m=0 -> result=%h busy=%b done=%b", result, busy, done);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      if ($urandom_range(0, 4) == 0) begin
        ra = W'($urandom); rb = W'($urandom);
      end else begin
        ra = int2bcd($urandom_range(0, 99)); rb = int2bcd($urandom_range(0, 99));
      end
      run_op(ra, rb, 1'($urandom), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
